// File: rtl/top_level.sv
// 16x16 unsigned shift-add multiply engine with a private 256x8 data memory
// (DM1) and an 8x8 scratch register file (RF1) used to stage operand bytes.

module top_level_dm #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] Core [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) Core[waddr] <= wdata;
  end

  assign rdata = Core[raddr];
endmodule

module top_level_rf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] Registers [8];

  always_ff @(posedge clk) begin
    if (we) Registers[waddr] <= wdata;
  end

  assign rdata = Registers[raddr];
endmodule

module top_level #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int A_ADDR = 1,
  parameter int B_ADDR = 3,
  parameter int P_ADDR = 5
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  localparam int OP_W   = 2 * DATA_W;
  localparam int PROD_W = 4 * DATA_W;
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(A_ADDR);
  localparam logic [ADDR_W-1:0] B_BASE = ADDR_W'(B_ADDR);
  localparam logic [ADDR_W-1:0] P_BASE = ADDR_W'(P_ADDR);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                ack_q, ack_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;

  logic                dm_we;
  logic [ADDR_W-1:0]   dm_waddr, dm_raddr;
  logic [DATA_W-1:0]   dm_wdata, dm_rdata;
  logic                rf_we;
  logic [2:0]          rf_waddr, rf_raddr;
  logic [DATA_W-1:0]   rf_rdata;

  top_level_dm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) DM1 (
    .clk(Clk), .we(dm_we), .waddr(dm_waddr), .wdata(dm_wdata),
    .raddr(dm_raddr), .rdata(dm_rdata)
  );

  top_level_rf #(.DATA_W(DATA_W)) RF1 (
    .clk(Clk), .we(rf_we), .waddr(rf_waddr), .wdata(dm_rdata),
    .raddr(rf_raddr), .rdata(rf_rdata)
  );

  // LOAD byte k comes from DM and is parked in RF[k]; the operand registers
  // pick up byte k-1 from RF, and the final byte straight from DM.
  assign dm_raddr = (cnt_q[1] ? B_BASE : A_BASE) + ADDR_W'(cnt_q[0]);
  assign rf_we    = (state_q == LOAD);
  assign rf_waddr = {1'b0, cnt_q[1:0]};
  assign rf_raddr = {1'b0, cnt_q[1:0] - 2'd1};

  assign dm_we    = (state_q == STORE);
  assign dm_waddr = P_BASE + ADDR_W'(cnt_q[1:0]);

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    dm_wdata = acc_q[4*DATA_W-1 -: DATA_W];
      2'd1:    dm_wdata = acc_q[3*DATA_W-1 -: DATA_W];
      2'd2:    dm_wdata = acc_q[2*DATA_W-1 -: DATA_W];
      default: dm_wdata = acc_q[DATA_W-1 -: DATA_W];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d  = 1'b0;
          state_d  = LOAD;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = '0;
          mplier_d = '0;
        end
      end
      LOAD: begin
        case (cnt_q[1:0])
          2'd1:    mcand_d[OP_W-1:DATA_W] = rf_rdata;
          2'd2:    mcand_d[DATA_W-1:0]    = rf_rdata;
          2'd3:    mplier_d               = {rf_rdata, dm_rdata};
          default: ;
        endcase
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          state_d = MUL;
          cnt_d   = '0;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = STORE;
          cnt_d   = '0;
        end
      end
      STORE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      ack_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign Ack = ack_q;
endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the top_level multiply engine: products come from
// plain 32-bit multiplication, memory integrity from snapshots of DM1.Core.

module tb_top_level;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic Ack;

  int tests = 0;
  int fails = 0;
  logic [7:0] snap [256];

  always #5 Clk = ~Clk;

  top_level dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Ack(Ack)
  );

  task automatic take_snap();
    for (int i = 0; i < 256; i++) snap[i] = dut.DM1.Core[i];
  endtask

  task automatic fill_rf_garbage();
    for (int i = 0; i < 8; i++) dut.RF1.Registers[i] = 8'($urandom);
  endtask

  // Counts bytes differing from the snapshot, optionally skipping the product window.
  task automatic count_changes(input bit skip_prod, output int n);
    logic [7:0] v;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      v = dut.DM1.Core[i];
      if (!(skip_prod && i >= 5 && i <= 8) && v !== snap[i]) n++;
    end
  endtask

  // Arms with operands preloaded, launches, counts 25 edges, checks everything.
  task automatic launch_run(input logic [15:0] a, input logic [15:0] b, input string name);
    logic [31:0] exp_p;
    logic [31:0] got_p;
    int early;
    int changed;
    exp_p = {16'h0, a} * {16'h0, b};
    @(negedge Clk);
    Start = 1'b1;
    dut.DM1.Core[1] = a[15:8];
    dut.DM1.Core[2] = a[7:0];
    dut.DM1.Core[3] = b[15:8];
    dut.DM1.Core[4] = b[7:0];
    @(posedge Clk); #1;
    tests++;
    if (Ack !== 1'b0) begin
      fails++;
      $display("FAIL %s ack_after_arm: got %b want 0", name, Ack);
    end
    take_snap();
    @(negedge Clk);
    Start = 1'b0;
    early = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge Clk); #1;
      if (e < 25 && Ack !== 1'b0) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL %s ack_early: got %0d early cycles want 0", name, early);
    end
    tests++;
    if (Ack !== 1'b1) begin
      fails++;
      $display("FAIL %s ack_at_25: got %b want 1", name, Ack);
    end
    got_p = {dut.DM1.Core[5], dut.DM1.Core[6], dut.DM1.Core[7], dut.DM1.Core[8]};
    tests++;
    if (got_p !== exp_p) begin
      fails++;
      $display("FAIL %s product: got %h want %h", name, got_p, exp_p);
    end
    count_changes(1'b1, changed);
    tests++;
    if (changed != 0) begin
      fails++;
      $display("FAIL %s other_mem: got %0d changed bytes want 0", name, changed);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) dut.DM1.Core[i] = 8'($urandom);
    fill_rf_garbage();
    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    if (Ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_ack: got %b want 0", Ack);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_no_launch();
    int high;
    int changed;
    take_snap();
    high = 0;
    repeat (60) begin
      @(posedge Clk); #1;
      if (Ack !== 1'b0) high++;
    end
    tests++;
    if (high != 0) begin
      fails++;
      $display("FAIL no_launch_ack: got %0d high cycles want 0", high);
    end
    count_changes(1'b0, changed);
    tests++;
    if (changed != 0) begin
      fails++;
      $display("FAIL no_launch_mem: got %0d changed bytes want 0", changed);
    end
  endtask

  task automatic test_basic();
    launch_run(16'h03FF, 16'hFFFB, "basic");
  endtask

  task automatic test_max();
    launch_run(16'hFFFF, 16'hFFFF, "max");
  endtask

  task automatic test_zero_garbage_rf();
    fill_rf_garbage();
    dut.DM1.Core[5] = 8'hA5;
    dut.DM1.Core[8] = 8'h5A;
    launch_run(16'h0000, 16'h1234, "zero");
  endtask

  task automatic test_back_to_back();
    int drops;
    drops = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (Ack !== 1'b1) drops++;
    end
    tests++;
    if (drops != 0) begin
      fails++;
      $display("FAIL done_hold: got %0d low cycles want 0", drops);
    end
    launch_run(16'h0002, 16'h8000, "b2b");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (k == 0) a = 16'hFFFF;
      if (k == 1) b = 16'h0001;
      fill_rf_garbage();
      launch_run(a, b, $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_mid_reset();
    int high;
    int changed;
    // Reset while DONE: Ack must fall without waiting for a clock edge.
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (Ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_from_done: got %b want 0", Ack);
    end
    @(negedge Clk);
    Reset = 1'b1;
    // Abort a run at edge 10, before any product byte is written.
    @(negedge Clk);
    Start = 1'b1;
    dut.DM1.Core[1] = 8'h12;
    dut.DM1.Core[2] = 8'h34;
    dut.DM1.Core[3] = 8'h56;
    dut.DM1.Core[4] = 8'h78;
    dut.DM1.Core[5] = 8'hC3;
    dut.DM1.Core[6] = 8'hC3;
    dut.DM1.Core[7] = 8'hC3;
    dut.DM1.Core[8] = 8'hC3;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (Ack !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ack: got %b want 0", Ack);
    end
    take_snap();
    @(negedge Clk);
    Reset = 1'b1;
    high = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Ack !== 1'b0) high++;
    end
    tests++;
    if (high != 0) begin
      fails++;
      $display("FAIL post_reset_idle: got %0d high cycles want 0", high);
    end
    count_changes(1'b0, changed);
    tests++;
    if (changed != 0) begin
      fails++;
      $display("FAIL post_reset_mem: got %0d changed bytes want 0", changed);
    end
    launch_run(16'hBEEF, 16'h0101, "after_reset");
  endtask

  initial begin
    test_reset();
    test_no_launch();
    test_basic();
    test_max();
    test_zero_garbage_rf();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
